// File: rtl/serial_adder_nb.sv
// rtl/serial_adder_nb.sv - digit-serial WIDTH-bit adder with start/done handshake and CPU flags (optional subtract: SERIAL_ADDER_SUB_EN)
module serial_adder_nb #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    input  logic             input_carry,
    input  logic             op,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] output_sum,
    output logic             output_carry,
    output logic             flag_zero,
    output logic             flag_negative,
    output logic             flag_overflow
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    generate
        if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_adder_nb: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry_r;

    logic [DIGIT:0]   c;
    logic [DIGIT-1:0] dsum;
    logic [WIDTH-1:0] sum_next;

`ifndef SERIAL_ADDER_SUB_EN
    // op has no function in add-only builds; kept as a port for a uniform interface
    logic unused_op;
    assign unused_op = op;
`endif

    // Ripple add of the current low digit; c[DIGIT-1] is the carry into the digit's top bit
    always_comb begin
        c    = '0;
        dsum = '0;
        c[0] = carry_r;
        for (int i = 0; i < DIGIT; i++) begin
            dsum[i]  = a_sh[i] ^ b_sh[i] ^ c[i];
            c[i + 1] = (a_sh[i] & b_sh[i]) | (c[i] & (a_sh[i] ^ b_sh[i]));
        end
        sum_next = (sum_sh >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
    end

    // Control FSM, operand shifters and registered result/flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            count         <= '0;
            a_sh          <= '0;
            b_sh          <= '0;
            sum_sh        <= '0;
            carry_r       <= 1'b0;
            ready         <= 1'b1;
            done          <= 1'b0;
            output_sum    <= '0;
            output_carry  <= 1'b0;
            flag_zero     <= 1'b0;
            flag_negative <= 1'b0;
            flag_overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh <= input_a;
`ifdef SERIAL_ADDER_SUB_EN
                        // Subtract as A + ~B + ~borrow_in
                        b_sh    <= op ? ~input_b : input_b;
                        carry_r <= op ? ~input_carry : input_carry;
`else
                        b_sh    <= input_b;
                        carry_r <= input_carry;
`endif
                        sum_sh <= '0;
                        count  <= '0;
                        ready  <= 1'b0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> DIGIT;
                    b_sh    <= b_sh >> DIGIT;
                    sum_sh  <= sum_next;
                    carry_r <= c[DIGIT];
                    count   <= count + 1'b1;
                    if (count == LAST) begin
                        state         <= DONE;
                        done          <= 1'b1;
                        output_sum    <= sum_next;
                        output_carry  <= c[DIGIT];
                        flag_zero     <= (sum_next == '0);
                        flag_negative <= sum_next[WIDTH-1];
                        flag_overflow <= c[DIGIT-1] ^ c[DIGIT];
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_nb.sv
// tb/tb_serial_adder_nb.sv - directed and exhaustive checks of serial_adder_nb (SERIAL_ADDER_SUB_EN aware)
module tb_serial_adder_nb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       cin;
    logic       op;
    logic [7:0] a8, b8;
    logic [3:0] a4, b4;

    int checks = 0;
    int errors = 0;

    logic       rdy81, dn81, c81, z81, n81, v81;
    logic [7:0] s81;
    logic       rdy84, dn84, c84, z84, n84, v84;
    logic [7:0] s84;

    logic [2:0] rdy4, dn4, c4, z4, n4, v4;
    logic [3:0] s4 [3];

    logic [7:0] last_sum = 8'h00;

    always #5 clk = ~clk;

    serial_adder_nb #(.WIDTH(8), .DIGIT(1)) u8d1 (
        .clk(clk), .rst_n(rst_n), .start(start), .input_a(a8), .input_b(b8),
        .input_carry(cin), .op(op), .ready(rdy81), .done(dn81), .output_sum(s81),
        .output_carry(c81), .flag_zero(z81), .flag_negative(n81), .flag_overflow(v81));

    serial_adder_nb #(.WIDTH(8), .DIGIT(4)) u8d4 (
        .clk(clk), .rst_n(rst_n), .start(start), .input_a(a8), .input_b(b8),
        .input_carry(cin), .op(op), .ready(rdy84), .done(dn84), .output_sum(s84),
        .output_carry(c84), .flag_zero(z84), .flag_negative(n84), .flag_overflow(v84));

    serial_adder_nb #(.WIDTH(4), .DIGIT(1)) u4d1 (
        .clk(clk), .rst_n(rst_n), .start(start), .input_a(a4), .input_b(b4),
        .input_carry(cin), .op(op), .ready(rdy4[0]), .done(dn4[0]), .output_sum(s4[0]),
        .output_carry(c4[0]), .flag_zero(z4[0]), .flag_negative(n4[0]), .flag_overflow(v4[0]));

    serial_adder_nb #(.WIDTH(4), .DIGIT(2)) u4d2 (
        .clk(clk), .rst_n(rst_n), .start(start), .input_a(a4), .input_b(b4),
        .input_carry(cin), .op(op), .ready(rdy4[1]), .done(dn4[1]), .output_sum(s4[1]),
        .output_carry(c4[1]), .flag_zero(z4[1]), .flag_negative(n4[1]), .flag_overflow(v4[1]));

    serial_adder_nb #(.WIDTH(4), .DIGIT(4)) u4d4 (
        .clk(clk), .rst_n(rst_n), .start(start), .input_a(a4), .input_b(b4),
        .input_carry(cin), .op(op), .ready(rdy4[2]), .done(dn4[2]), .output_sum(s4[2]),
        .output_carry(c4[2]), .flag_zero(z4[2]), .flag_negative(n4[2]), .flag_overflow(v4[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One 8-bit operation on both 8-bit units; optional second start pulse while running
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic o,
                        input bit restart, input logic [7:0] es, input logic ec,
                        input logic ez, input logic en, input logic ev);
        a8 = a; b8 = b; cin = c; op = o; start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (k == 1) begin
                a8 = ~a; b8 = 8'h55; cin = ~c;
                if (restart) start = 1'b1;
            end
            chk("d1_done", dn81, (k == 9));
            chk("d4_done", dn84, (k == 3));
            if (k == 5) chk("d1_hold_in_run", s81, last_sum);
            if (k == 9) begin
                chk("d1_sum", s81, es); chk("d1_carry", c81, ec);
                chk("d1_z", z81, ez); chk("d1_n", n81, en); chk("d1_v", v81, ev);
            end
            if (k == 3) begin
                chk("d4_sum", s84, es); chk("d4_carry", c84, ec);
                chk("d4_z", z84, ez); chk("d4_n", n84, en); chk("d4_v", v84, ev);
            end
        end
        chk("d1_ready_after", rdy81, 1'b1);
        chk("d4_ready_after", rdy84, 1'b1);
        last_sum = es;
    endtask

    // One 4-bit operation on all three 4-bit units, checked against a reference model
    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic c, input logic o);
        logic [3:0] bb;
        logic       cc;
        logic [4:0] full;
        logic [3:0] low3;
        logic       exp_v;
        int         lat;
        bb = b; cc = c;
`ifdef SERIAL_ADDER_SUB_EN
        if (o) begin bb = ~b; cc = ~c; end
`endif
        full  = {1'b0, a} + {1'b0, bb} + {4'b0, cc};
        low3  = {1'b0, a[2:0]} + {1'b0, bb[2:0]} + {3'b0, cc};
        exp_v = low3[3] ^ full[4];
        a4 = a; b4 = b; cin = c; op = o; start = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            for (int u = 0; u < 3; u++) begin
                lat = (u == 0) ? 5 : (u == 1) ? 3 : 2;
                chk($sformatf("w4u%0d_done a=%h b=%h c=%b op=%b", u, a, b, c, o), dn4[u], (k == lat));
                if (k == lat) begin
                    chk($sformatf("w4u%0d_sum a=%h b=%h c=%b op=%b", u, a, b, c, o), s4[u], full[3:0]);
                    chk($sformatf("w4u%0d_carry a=%h b=%h c=%b op=%b", u, a, b, c, o), c4[u], full[4]);
                    chk($sformatf("w4u%0d_z a=%h b=%h", u, a, b), z4[u], (full[3:0] == 4'h0));
                    chk($sformatf("w4u%0d_n a=%h b=%h", u, a, b), n4[u], full[3]);
                    chk($sformatf("w4u%0d_v a=%h b=%h c=%b op=%b", u, a, b, c, o), v4[u], exp_v);
                end
            end
        end
        chk("w4_ready_after", rdy4, 3'b111);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; cin = 1'b0; op = 1'b0;
        a8 = 8'h00; b8 = 8'h00; a4 = 4'h0; b4 = 4'h0;
        #12;
        chk("rst_ready", rdy81, 1'b1);
        chk("rst_done", dn81, 1'b0);
        chk("rst_sum", s81, 8'h00);
        chk("rst_flags", {c81, z81, n81, v81}, 4'b0000);
        chk("rst_ready_w4", rdy4, 3'b111);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run8(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1);
        run8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        run8(8'h3C, 8'h0F, 1'b1, 1'b0, 1'b0, 8'h4C, 1'b0, 1'b0, 1'b0, 1'b0);
        run8(8'h10, 8'h20, 1'b0, 1'b0, 1'b1, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef SERIAL_ADDER_SUB_EN
        run8(8'h05, 8'h07, 1'b0, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0);
        run8(8'h80, 8'h01, 1'b0, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b1);
`else
        run8(8'h05, 8'h07, 1'b0, 1'b1, 1'b0, 8'h0C, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

        // Abort a running operation with reset
        a8 = 8'h12; b8 = 8'h34; cin = 1'b0; op = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("abort_ready", rdy81, 1'b1);
        chk("abort_done", dn81, 1'b0);
        chk("abort_sum", s81, 8'h00);
        chk("abort_flags", {c81, z81, n81, v81}, 4'b0000);
        chk("abort_d4_sum", s84, 8'h00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk("abort_no_done", {dn81, dn84}, 2'b00);
        end
        last_sum = 8'h00;

        for (int oi = 0; oi < 2; oi++) begin
            for (int ci = 0; ci < 2; ci++) begin
                for (int ai = 0; ai < 16; ai++) begin
                    for (int bi = 0; bi < 16; bi++) begin
                        run4(4'(ai), 4'(bi), 1'(ci), 1'(oi));
                    end
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
